program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: Program_Loader

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: pulls a framed program image out of the UART receive FIFO and
// writes it word-by-word into instruction memory, verifying an XOR checksum.
module program_loader #(
    parameter logic [7:0]  CMD_LOAD = 8'h4C,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uartDataAvailable,
    input  logic [7:0]        uartFifoDataIn,
    output logic              readFlag,
    output logic              imemWe,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [31:0]       imemData,
    output logic              datapathHold,
    output logic              loadDone,
    output logic              loadError,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_CNT  = 3'd1,
        GET_BYTE = 3'd2,
        WRITE    = 3'd3,
        GET_CSUM = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t              state_r;
    logic [1:0]          byteIdx_r;
    logic [8:0]          remaining_r;
    logic [ADDR_W-1:0]   wordIdx_r;
    logic [7:0]          csum_r;
    logic [31:0]         asm_r;
    logic                popNow_s;
    logic [31:0]         asmNext_s;

    function automatic logic [7:0] csumNext(input logic [7:0] csum, input logic [7:0] dataByte);
        return csum ^ dataByte;
    endfunction

    function automatic logic consumesByte(input state_t s);
        case (s)
            IDLE, GET_CNT, GET_BYTE, GET_CSUM: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Pop request: a byte-consuming state with data waiting, never right after a pop.
    always_comb begin
        popNow_s  = 1'b0;
        asmNext_s = {asm_r[23:0], uartFifoDataIn};
        if (!readFlag && uartDataAvailable) begin
            popNow_s = consumesByte(state_r);
        end else begin
            popNow_s = 1'b0;
        end
    end

    // Loader FSM; the byte is taken on the cycle readFlag is high (FIFO head is the popped byte).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            byteIdx_r    <= 2'd0;
            remaining_r  <= 9'd0;
            wordIdx_r    <= {ADDR_W{1'b0}};
            csum_r       <= 8'h00;
            asm_r        <= 32'h0000_0000;
            readFlag     <= 1'b0;
            imemWe       <= 1'b0;
            imemAddr     <= {ADDR_W{1'b0}};
            imemData     <= 32'h0000_0000;
            datapathHold <= 1'b0;
            loadDone     <= 1'b0;
            loadError    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            readFlag <= popNow_s;
            imemWe   <= 1'b0;
            loadDone <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (readFlag && (uartFifoDataIn == CMD_LOAD)) begin
                        state_r      <= GET_CNT;
                        loadError    <= 1'b0;
                        wordIdx_r    <= {ADDR_W{1'b0}};
                        csum_r       <= 8'h00;
                        datapathHold <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                GET_CNT: begin
                    if (readFlag) begin
                        remaining_r <= (uartFifoDataIn == 8'h00) ? 9'd256 : {1'b0, uartFifoDataIn};
                        byteIdx_r   <= 2'd0;
                        state_r     <= GET_BYTE;
                    end
                end
                GET_BYTE: begin
                    if (readFlag) begin
                        asm_r     <= asmNext_s;
                        csum_r    <= csumNext(csum_r, uartFifoDataIn);
                        byteIdx_r <= byteIdx_r + 2'd1;
                        // Present the word on the memory port as we enter WRITE.
                        if (byteIdx_r == 2'd3) begin
                            state_r  <= WRITE;
                            imemWe   <= 1'b1;
                            imemAddr <= wordIdx_r;
                            imemData <= asmNext_s;
                        end
                    end
                end
                WRITE: begin
                    wordIdx_r   <= wordIdx_r + ADDR_W'(1'b1);
                    remaining_r <= remaining_r - 9'd1;
                    state_r     <= (remaining_r == 9'd1) ? GET_CSUM : GET_BYTE;
                end
                GET_CSUM: begin
                    if (readFlag) begin
                        if (uartFifoDataIn == csum_r) begin
                            state_r  <= DONE;
                            loadDone <= 1'b1;
                        end else begin
                            state_r   <= ERROR;
                            loadError <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    state_r      <= IDLE;
                    datapathHold <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    datapathHold <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a behavioural receive FIFO feeds frames,
// expected writes and load outcomes are queued at stimulus time and popped on output.
module tb_program_loader;

    localparam logic [7:0] CMD = 8'h4C;

    logic        clk = 1'b0;
    logic        reset;
    logic        uartDataAvailable;
    logic [7:0]  uartFifoDataIn;
    logic        readFlag;
    logic        imemWe;
    logic [7:0]  imemAddr;
    logic [31:0] imemData;
    logic        datapathHold;
    logic        loadDone;
    logic        loadError;
    logic        busy;

    always #5 clk = ~clk;

    program_loader #(.CMD_LOAD(CMD), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .uartDataAvailable(uartDataAvailable), .uartFifoDataIn(uartFifoDataIn),
        .readFlag(readFlag), .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
        .datapathHold(datapathHold), .loadDone(loadDone), .loadError(loadError), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int popCount = 0;
    bit monOn = 1'b0;

    logic [7:0]  fifoQ[$];
    logic [7:0]  frameQ[$];
    logic [31:0] wordsQ[$];
    logic [39:0] expWr[$];
    bit          expEvt[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Receive FIFO model: pops on a posedge where readFlag is high, head shown after.
    initial begin
        bit popNow;
        uartDataAvailable = 1'b0;
        uartFifoDataIn    = 8'h00;
        forever begin
            @(negedge clk);
            popNow = (readFlag === 1'b1);
            @(posedge clk);
            #1;
            if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
            uartDataAvailable = (fifoQ.size() > 0);
            uartFifoDataIn    = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
        end
    end

    // Output monitor: pop spacing, memory writes and load outcomes against the scoreboard.
    initial begin
        bit prevRf, prevDone, prevErr, e;
        logic [39:0] w;
        prevRf = 1'b0; prevDone = 1'b0; prevErr = 1'b0;
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (readFlag === 1'b1) begin
                    popCount++;
                    checkVal("rfGap", 32'(prevRf), 32'd0);
                end
                if (imemWe === 1'b1) begin
                    checkVal("weHold", 32'({busy, datapathHold}), 32'd3);
                    checkVal("wrPending", 32'(expWr.size() > 0), 32'd1);
                    if (expWr.size() > 0) begin
                        w = expWr.pop_front();
                        checkVal("wrAddr", 32'(imemAddr), 32'(w[39:32]));
                        checkVal("wrData", imemData, w[31:0]);
                    end
                end
                if (loadDone === 1'b1 || (loadError === 1'b1 && !prevErr)) begin
                    checkVal("donePulse", 32'(prevDone), 32'd0);
                    checkVal("evtPending", 32'(expEvt.size() > 0), 32'd1);
                    if (expEvt.size() > 0) begin
                        e = expEvt.pop_front();
                        checkVal("evtKind", 32'({loadError, loadDone}), e ? 32'd2 : 32'd1);
                    end
                end
            end
            prevRf   = (readFlag === 1'b1);
            prevDone = (loadDone === 1'b1);
            prevErr  = (loadError === 1'b1);
        end
    end

    task automatic resetDut();
        @(negedge clk);
        monOn = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkVal("rstCtl", 32'({readFlag, imemWe, datapathHold, loadDone, loadError, busy}), 32'd0);
        checkVal("rstAddr", 32'(imemAddr), 32'd0);
        checkVal("rstData", imemData, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fifoQ.delete();
        expWr.delete();
        expEvt.delete();
        monOn = 1'b1;
    endtask

    // Builds a frame in frameQ; only words/outcome reached within the first 'cut' bytes are expected.
    task automatic buildFrame(input int count, input logic [7:0] csumFlip, input int cut);
        logic [7:0]  cs;
        logic [31:0] w;
        frameQ.delete();
        cs = 8'h00;
        frameQ.push_back(CMD);
        frameQ.push_back(count[7:0]);
        for (int i = 0; i < count; i++) begin
            w = (i < wordsQ.size()) ? wordsQ[i] : $urandom;
            for (int b = 3; b >= 0; b--) begin
                frameQ.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
            if (2 + 4*i + 3 < cut) expWr.push_back({i[7:0], w});
        end
        frameQ.push_back(cs ^ csumFlip);
        if (cut >= frameQ.size()) expEvt.push_back(csumFlip != 8'h00);
        wordsQ.delete();
    endtask

    task automatic pushRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) fifoQ.push_back(frameQ[i]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((fifoQ.size() > 0 || busy !== 1'b0 || readFlag !== 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, 32'(n < 20000), 32'd1);
    endtask

    task automatic waitPops(input string tag, input int base, input int n);
        int k = 0;
        while (popCount - base < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkVal(tag, 32'(popCount - base), 32'(n));
    endtask

    task automatic frameEnd(input logic expErr);
        checkVal("wrLeft", 32'(expWr.size()), 32'd0);
        checkVal("evtLeft", 32'(expEvt.size()), 32'd0);
        checkVal("loadErr", 32'(loadError), 32'(expErr));
    endtask

    initial begin
        int p0;
        bit stallOk;
        reset = 1'b1;
        resetDut();

        // Single word, valid checksum.
        wordsQ.push_back(32'h2008_0005);
        buildFrame(1, 8'h00, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle1");
        frameEnd(1'b0);

        // Two words 00..07, good checksum then corrupted checksum.
        wordsQ.push_back(32'h0001_0203); wordsQ.push_back(32'h0405_0607);
        buildFrame(2, 8'h00, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle2");
        frameEnd(1'b0);
        wordsQ.push_back(32'h0001_0203); wordsQ.push_back(32'h0405_0607);
        buildFrame(2, 8'h01, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle3");
        frameEnd(1'b1);

        // Junk before the command, command-valued bytes inside the data.
        p0 = popCount;
        fifoQ.push_back(8'h11); fifoQ.push_back(8'h22);
        wordsQ.push_back(32'h4C4C_0001); wordsQ.push_back(32'h0000_004C);
        buildFrame(3, 8'h00, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle4");
        frameEnd(1'b0);
        checkVal("popCnt", 32'(popCount - p0), 32'(frameQ.size() + 2));

        // FIFO runs dry mid-word for 100 cycles.
        p0 = popCount;
        buildFrame(2, 8'h00, 1 << 20);
        pushRange(0, 4);
        waitPops("stallPops", p0, 4);
        repeat (3) @(negedge clk);
        stallOk = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || datapathHold !== 1'b1 || readFlag !== 1'b0 || imemWe !== 1'b0)
                stallOk = 1'b0;
        end
        checkVal("stallHeld", 32'(stallOk), 32'd1);
        checkVal("stallPopCnt", 32'(popCount - p0), 32'd4);
        pushRange(4, frameQ.size());
        waitIdle("idle5");
        frameEnd(1'b0);

        // COUNT=0 means 256 words at addresses 0..255.
        buildFrame(256, 8'h00, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle6");
        frameEnd(1'b0);

        // Reset after the second byte of word 1, then a clean frame.
        p0 = popCount;
        buildFrame(2, 8'h00, 8);
        pushRange(0, 8);
        waitPops("prePops", p0, 8);
        repeat (3) @(negedge clk);
        checkVal("preRstWr", 32'(expWr.size()), 32'd0);
        resetDut();
        buildFrame(2, 8'h00, 1 << 20);
        pushRange(0, frameQ.size());
        waitIdle("idle7");
        frameEnd(1'b0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
